// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: multi-digit packed-BCD stopwatch with start/resume, pause,
// wrap-around overflow pulse and an optional lap-hold display freeze.
// Optional feature macro: LAP_HOLD_EN (lap-hold freeze of the displayed count).
// Digit 0 is least significant; number[4i+3:4i] is digit i.
module bcd_stopwatch #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_resume,
    input  logic                  stop,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   number,
    output logic                  running,
    output logic                  overflow,
    output logic                  lap_held
);

    localparam int unsigned NUM_W = 4 * DIGITS;
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               running_d;
    logic [PRE_W-1:0]   pre_q;
    logic [PRE_W-1:0]   pre_d;
    logic               tick;
    logic [NUM_W-1:0]   count_q;
    logic [NUM_W-1:0]   count_d;
    logic               carry;
    logic               wrap;
    logic [NUM_W-1:0]   number_d;
    logic               lap_held_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop has priority over start_resume while running
    always_comb begin
        state_d   = state_q;
        running_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_resume) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start_resume) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        running_d = (state_d == S_RUN);
    end

    // Prescaler: advances only while running and not being stopped this edge
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pre_d = '0;
            end
            S_RUN: begin
                if (!stop) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        tick  = 1'b1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            default: begin
                pre_d = pre_q;
            end
        endcase
    end

    // Ripple BCD incrementer; carry out of the top digit marks the wrap
    always_comb begin
        count_d = count_q;
        carry   = tick;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        wrap = carry;
    end

`ifdef LAP_HOLD_EN
    // Display select: freeze/release on lap; both toggles load the pre-increment count
    always_comb begin
        number_d   = count_d;
        lap_held_d = lap_held;
        if (lap && (state_q != S_IDLE)) begin
            lap_held_d = !lap_held;
            number_d   = count_q;
        end else if (lap_held) begin
            number_d = number;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;

    // Display always follows the internal count
    always_comb begin
        number_d   = count_d;
        lap_held_d = 1'b0;
    end
`endif

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q    <= '0;
            count_q  <= '0;
            number   <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
            lap_held <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            count_q  <= count_d;
            number   <= number_d;
            running  <= running_d;
            overflow <= wrap;
            lap_held <= lap_held_d;
        end
    end

endmodule
